// File: rtl/rs_br.sv
// Branch reservation station: holds branch/jump ops until both operands are ready,
// then issues the lowest-index ready entry as a registered packet to fu_br.
`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif
`ifndef ROB_IDX_W
`define ROB_IDX_W 5
`endif
`ifndef BR_MASK_W
`define BR_MASK_W 4
`endif
`ifndef ZERO_REG
`define ZERO_REG '0
`endif

module rs_br #(
  parameter int RS_NUM   = 4,
  parameter int RS_IDX_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  disp_en_i,
  input  logic [63:0]           disp_npc_i,
  input  logic [31:0]           disp_inst_i,
  input  logic [`PRF_IDX_W-1:0] disp_opa_tag_i,
  input  logic                  disp_opa_rdy_i,
  input  logic [`PRF_IDX_W-1:0] disp_opb_tag_i,
  input  logic                  disp_opb_rdy_i,
  input  logic [`PRF_IDX_W-1:0] disp_dest_tag_i,
  input  logic [`ROB_IDX_W:0]   disp_rob_idx_i,
  input  logic [`BR_MASK_W-1:0] disp_br_mask_i,
  input  logic                  cdb_valid_i,
  input  logic [`PRF_IDX_W-1:0] cdb_tag_i,
  input  logic                  rob_br_recovery_i,
  input  logic [`BR_MASK_W-1:0] rob_br_tag_fix_i,
  input  logic                  br_clear_en_i,
  input  logic [`BR_MASK_W-1:0] br_clear_mask_i,
  output logic [`PRF_IDX_W-1:0] prf_opa_tag_o,
  output logic [`PRF_IDX_W-1:0] prf_opb_tag_o,
  input  logic [63:0]           prf_opa_val_i,
  input  logic [63:0]           prf_opb_val_i,
  output logic                  rs_full_o,
  output logic                  start_o,
  output logic [63:0]           npc_o,
  output logic [31:0]           inst_o,
  output logic [63:0]           opa_o,
  output logic [63:0]           opb_o,
  output logic [`PRF_IDX_W-1:0] dest_tag_o,
  output logic [`ROB_IDX_W:0]   rob_idx_o,
  output logic [`BR_MASK_W-1:0] br_mask_o
);

  // Stage p0: entry storage
  logic [RS_NUM-1:0]     vld_p0, opa_rdy_p0, opb_rdy_p0;
  logic [63:0]           npc_p0  [RS_NUM];
  logic [31:0]           inst_p0 [RS_NUM];
  logic [`PRF_IDX_W-1:0] opa_tag_p0 [RS_NUM];
  logic [`PRF_IDX_W-1:0] opb_tag_p0 [RS_NUM];
  logic [`PRF_IDX_W-1:0] dest_p0 [RS_NUM];
  logic [`ROB_IDX_W:0]   rob_p0  [RS_NUM];
  logic [`BR_MASK_W-1:0] mask_p0 [RS_NUM];

  // Stage p1: registered issue packet
  logic                  vld_p1;
  logic [63:0]           npc_p1, opa_p1, opb_p1;
  logic [31:0]           inst_p1;
  logic [`PRF_IDX_W-1:0] dest_p1;
  logic [`ROB_IDX_W:0]   rob_p1;
  logic [`BR_MASK_W-1:0] mask_p1;

  logic [RS_NUM-1:0]     rdy_vec;
  logic [RS_IDX_W-1:0]   free_idx, iss_idx;
  logic                  disp_go, iss_go, disp_opa_rdy, disp_opb_rdy;
  logic [`BR_MASK_W-1:0] keep_mask;

  assign rs_full_o = &vld_p0;
  assign rdy_vec   = vld_p0 & opa_rdy_p0 & opb_rdy_p0;
  assign disp_go   = disp_en_i & ~rs_full_o & ~rob_br_recovery_i;
  assign iss_go    = (|rdy_vec) & ~rob_br_recovery_i;
  assign keep_mask = (br_clear_en_i && !rob_br_recovery_i) ? ~br_clear_mask_i : '1;

  // A CDB broadcast in the dispatch cycle would otherwise be missed by the new entry.
  assign disp_opa_rdy = disp_opa_rdy_i || (disp_opa_tag_i == `ZERO_REG) ||
                        (cdb_valid_i && cdb_tag_i == disp_opa_tag_i);
  assign disp_opb_rdy = disp_opb_rdy_i || (disp_opb_tag_i == `ZERO_REG) ||
                        (cdb_valid_i && cdb_tag_i == disp_opb_tag_i);

  always_comb begin
    free_idx = '0;
    iss_idx  = '0;
    for (int i = RS_NUM - 1; i >= 0; i--) begin
      if (!vld_p0[i])  free_idx = RS_IDX_W'(i);
      if (rdy_vec[i])  iss_idx  = RS_IDX_W'(i);
    end
  end

  assign prf_opa_tag_o = opa_tag_p0[iss_idx];
  assign prf_opb_tag_o = opb_tag_p0[iss_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= '0;
    end else begin
      for (int i = 0; i < RS_NUM; i++) begin
        if (rob_br_recovery_i && (mask_p0[i] & rob_br_tag_fix_i) != '0)
          vld_p0[i] <= 1'b0;
        else if (iss_go && iss_idx == RS_IDX_W'(i))
          vld_p0[i] <= 1'b0;
        if (cdb_valid_i && cdb_tag_i == opa_tag_p0[i]) opa_rdy_p0[i] <= 1'b1;
        if (cdb_valid_i && cdb_tag_i == opb_tag_p0[i]) opb_rdy_p0[i] <= 1'b1;
        mask_p0[i] <= mask_p0[i] & keep_mask;
      end
      if (disp_go) begin
        vld_p0[free_idx]     <= 1'b1;
        npc_p0[free_idx]     <= disp_npc_i;
        inst_p0[free_idx]    <= disp_inst_i;
        opa_tag_p0[free_idx] <= disp_opa_tag_i;
        opb_tag_p0[free_idx] <= disp_opb_tag_i;
        opa_rdy_p0[free_idx] <= disp_opa_rdy;
        opb_rdy_p0[free_idx] <= disp_opb_rdy;
        dest_p0[free_idx]    <= disp_dest_tag_i;
        rob_p0[free_idx]     <= disp_rob_idx_i;
        mask_p0[free_idx]    <= disp_br_mask_i & keep_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      npc_p1  <= '0;
      inst_p1 <= '0;
      opa_p1  <= '0;
      opb_p1  <= '0;
      dest_p1 <= '0;
      rob_p1  <= '0;
      mask_p1 <= '0;
    end else begin
      vld_p1 <= iss_go;
      if (iss_go) begin
        npc_p1  <= npc_p0[iss_idx];
        inst_p1 <= inst_p0[iss_idx];
        opa_p1  <= prf_opa_val_i;
        opb_p1  <= prf_opb_val_i;
        dest_p1 <= dest_p0[iss_idx];
        rob_p1  <= rob_p0[iss_idx];
        mask_p1 <= mask_p0[iss_idx] & keep_mask;
      end else begin
        mask_p1 <= mask_p1 & keep_mask;
      end
    end
  end

  assign start_o    = vld_p1;
  assign npc_o      = npc_p1;
  assign inst_o     = inst_p1;
  assign opa_o      = opa_p1;
  assign opb_o      = opb_p1;
  assign dest_tag_o = dest_p1;
  assign rob_idx_o  = rob_p1;
  assign br_mask_o  = mask_p1;

endmodule
